// File: rtl/decoder_pkg.sv
// Shared types and helpers for the one-hot select/strobe decoders.
package decoder_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_e;

   // Widest select any strobe block may use with onehot(); callers narrow the result.
   localparam int unsigned MAX_N     = 8;
   localparam int unsigned MAX_OUT_W = 1 << MAX_N;

   localparam int unsigned DEF_N     = 3;
   localparam int unsigned DEF_OUT_W = 1 << DEF_N;

   function automatic int unsigned out_width(input int unsigned n);
      return 1 << n;
   endfunction

   function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_N-1:0] sel);
      logic [MAX_OUT_W-1:0] r;
      r      = '0;
      r[sel] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational N to 2^N one-hot decoder.
module decoder_onehot
   import decoder_pkg::*;
#(
   parameter int unsigned N = 3
) (
   input  logic [N-1:0]             sel,
   output logic [(1 << N)-1:0]      onehot_c
);

   localparam int unsigned OUT_W = out_width(N);

   assign onehot_c = OUT_W'(onehot(MAX_N'(sel)));

endmodule

// File: rtl/decoder_seq.sv
// Registered one-hot decoder with valid/ready select and self-timed sweep mode.
// Sweep mode is built only when DECODER_SWEEP_EN is defined.
module decoder_seq
   import decoder_pkg::*;
#(
   parameter int unsigned N       = 3,
   parameter int unsigned DWELL_W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         sel,
   input  logic                 mode,
   input  logic [DWELL_W-1:0]   dwell,
   input  logic                 stop,
   input  logic                 en,
   output logic [(1 << N)-1:0]  d,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned OUT_W = out_width(N);

   logic [OUT_W-1:0] d_q, d_d;
   logic [OUT_W-1:0] next_onehot_c;
   logic [N-1:0]     next_idx_c;

   decoder_onehot #(.N(N)) u_onehot (
      .sel      (next_idx_c),
      .onehot_c (next_onehot_c)
   );

`ifdef DECODER_SWEEP_EN

   localparam logic [N-1:0] POS_LAST = '1;

   state_e             state_q, state_d;
   logic [N-1:0]       idx_q, idx_d;
   logic [N-1:0]       pos_q, pos_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               accept_c;

   assign in_ready = (state_q == IDLE);
   assign accept_c = in_valid && in_ready && !stop;

   // One decoder serves both the accepted start index and each sweep step.
   assign next_idx_c = (state_q == SWEEP) ? idx_q + 1'b1 : sel;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pos_d   = pos_q;
      cnt_d   = cnt_q;
      dwell_d = dwell_q;
      d_d     = d_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (stop) begin
               d_d = '0;
            end else if (accept_c) begin
               d_d = next_onehot_c;
               if (mode) begin
                  state_d = SWEEP;
                  idx_d   = sel;
                  cnt_d   = dwell;
                  dwell_d = dwell;
                  pos_d   = '0;
               end
            end
         end
         SWEEP: begin
            if (stop) begin
               d_d     = '0;
               state_d = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (pos_q != POS_LAST) begin
               idx_d = next_idx_c;
               d_d   = next_onehot_c;
               cnt_d = dwell_q;
               pos_d = pos_q + 1'b1;
            end else begin
               d_d     = '0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            d_d     = '0;
         end
      endcase

      busy_d = (state_d == SWEEP);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         pos_q   <= '0;
         cnt_q   <= '0;
         dwell_q <= '0;
         d_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pos_q   <= pos_d;
         cnt_q   <= cnt_d;
         dwell_q <= dwell_d;
         d_q     <= d_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;

`else

   logic unused_sweep_c;

   assign in_ready       = 1'b1;
   assign busy           = 1'b0;
   assign done           = 1'b0;
   assign next_idx_c     = sel;
   assign unused_sweep_c = ^{mode, dwell};

   // Every acceptance is a single latch; stop still clears the output.
   always_comb begin
      d_d = d_q;
      if (stop) begin
         d_d = '0;
      end else if (in_valid) begin
         d_d = next_onehot_c;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         d_q <= '0;
      end else begin
         d_q <= d_d;
      end
   end

`endif

   assign d = en ? d_q : '0;

endmodule
